// File: rtl/ssd_pkg.sv
// Shared types, constants and hex-to-segment table for the seven-segment scan controller.
package ssd_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Write port, digit enables and display pins of the scan controller.
interface ssd_scan_ctrl_if;
    logic       wr;
    logic [1:0] sel;
    logic [3:0] num;
    logic [3:0] en_mask;
    logic [3:0] anode;
    logic [6:0] cathode;
    logic [1:0] digit_idx;
    logic       frame_done;

    modport master (
        output wr, sel, num, en_mask,
        input  anode, cathode, digit_idx, frame_done
    );

    modport slave (
        input  wr, sel, num, en_mask,
        output anode, cathode, digit_idx, frame_done
    );
endinterface

// File: rtl/ssd_hex_decoder.sv
// Combinational hex digit to active-low seven-segment decoder.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(hex);
endmodule

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: four digit registers driven one at a time,
// with an optional all-dark gap between digits to suppress ghosting.
//
//  state | meaning
//  BLANK | all anodes off, waiting out the inter-digit gap
//  DRIVE | anode of digit_idx on (if enabled), its segments on cathode
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_CNT = 50000,
    parameter int BLANK_CNT   = 500
) (
    input  logic           clk,
    input  logic           reset,
    ssd_scan_ctrl_if.slave bus
);
    localparam int MAX_CNT = (REFRESH_CNT > BLANK_CNT) ? REFRESH_CNT : BLANK_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CNT > 0) ? CNT_W'(BLANK_CNT - 1) : '0;
    localparam logic [1:0]       LAST_IDX   = 2'(N_DIGITS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic             frame_nxt;
    logic [3:0]       digit_reg [N_DIGITS];
    logic [3:0]       mux_hex;
    logic [6:0]       mux_seg;
    logic [3:0]       anode_nxt, anode_q;
    logic [6:0]       cathode_nxt, cathode_q;
    logic             frame_q;

    // Outputs are computed from the next slot so the pins change on the same edge as the state.
    assign mux_hex = digit_reg[idx_nxt];

    ssd_hex_decoder u_dec (
        .hex (mux_hex),
        .seg (mux_seg)
    );

    // Digit registers: writes land in any state; reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) digit_reg[i] <= '0;
        end else if (bus.wr) begin
            digit_reg[bus.sel] <= bus.num;
        end
    end

    // Slot sequencing: counter runs up to the terminal count of the current state, then restarts at 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        frame_nxt = 1'b0;
        case (state)
            BLANK: begin
                if (BLANK_CNT == 0 || cnt == BLANK_LAST) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_nxt = (BLANK_CNT == 0) ? DRIVE : BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                    frame_nxt = (idx == LAST_IDX);
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pin values for the coming cycle; a masked digit stays dark but keeps its segment pattern.
    always_comb begin
        anode_nxt   = ANODE_OFF;
        cathode_nxt = SEG_OFF;
        if (state_nxt == DRIVE) begin
            cathode_nxt = mux_seg;
            if (bus.en_mask[idx_nxt]) anode_nxt[idx_nxt] = 1'b0;
        end
    end

    // State, counter and registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BLANK;
            cnt       <= '0;
            idx       <= '0;
            anode_q   <= ANODE_OFF;
            cathode_q <= SEG_OFF;
            frame_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            anode_q   <= anode_nxt;
            cathode_q <= cathode_nxt;
            frame_q   <= frame_nxt;
        end
    end

    assign bus.anode      = anode_q;
    assign bus.cathode    = cathode_q;
    assign bus.digit_idx  = idx;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: blanked build (u0) and no-blank build (u1).
module tb_ssd_scan_ctrl;

    logic clk;
    logic reset;
    logic rst1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int c1    = 0;

    logic [6:0] exp_seg  [4];
    logic [6:0] exp_seg1 [4];
    logic [3:0] exp_mask;

    ssd_scan_ctrl_if bus0 ();
    ssd_scan_ctrl_if bus1 ();

    ssd_scan_ctrl #(
        .N_DIGITS    (4),
        .REFRESH_CNT (8),
        .BLANK_CNT   (2)
    ) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    ssd_scan_ctrl #(
        .N_DIGITS    (4),
        .REFRESH_CNT (8),
        .BLANK_CNT   (0)
    ) u1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // One clock of u0, then check its pins against the frame timeline:
    // 2 blank cycles after reset, then per digit 8 drive + 2 blank cycles.
    task automatic step_u0();
        int k;
        int slot;
        int r;
        logic [3:0] ea;
        logic [6:0] ec;
        logic [1:0] ei;
        logic       ef;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        ea = 4'hF;
        ec = 7'h7F;
        ei = 2'd0;
        ef = 1'b0;
        if (cyc >= 2) begin
            k    = (cyc - 2) % 40;
            slot = k / 10;
            r    = k % 10;
            if (r < 8) begin
                ei = 2'(slot);
                ec = exp_seg[slot];
                if (exp_mask[slot]) ea = ~(4'b0001 << slot);
            end else begin
                ei = 2'(slot + 1);
                ef = (r == 8) && (slot == 3);
            end
        end
        chk("u0_anode",      32'(bus0.anode),      32'(ea));
        chk("u0_cathode",    32'(bus0.cathode),    32'(ec));
        chk("u0_digit_idx",  32'(bus0.digit_idx),  32'(ei));
        chk("u0_frame_done", 32'(bus0.frame_done), 32'(ef));
    endtask

    // One clock of u1 (no blanking): each digit driven 8 cycles back to back.
    task automatic step_u1();
        int k;
        int slot;
        logic [3:0] ea;
        logic       ef;
        @(posedge clk);
        @(negedge clk);
        c1++;
        k    = (c1 - 1) % 32;
        slot = k / 8;
        ea   = ~(4'b0001 << slot);
        ef   = (k == 0) && (c1 >= 33);
        chk("u1_anode",      32'(bus1.anode),      32'(ea));
        chk("u1_cathode",    32'(bus1.cathode),    32'(exp_seg1[slot]));
        chk("u1_digit_idx",  32'(bus1.digit_idx),  32'(slot));
        chk("u1_frame_done", 32'(bus1.frame_done), 32'(ef));
    endtask

    initial begin
        reset        = 1'b0;
        rst1         = 1'b0;
        bus0.wr      = 1'b0;
        bus0.sel     = 2'd0;
        bus0.num     = 4'h0;
        bus0.en_mask = 4'hF;
        bus1.wr      = 1'b0;
        bus1.sel     = 2'd0;
        bus1.num     = 4'h0;
        bus1.en_mask = 4'hF;
        exp_mask     = 4'hF;
        #1;
        reset = 1'b1;
        rst1  = 1'b1;
        @(negedge clk);
        @(negedge clk);

        chk("rst_anode",      32'(bus0.anode),      32'h0000000F);
        chk("rst_cathode",    32'(bus0.cathode),    32'h0000007F);
        chk("rst_digit_idx",  32'(bus0.digit_idx),  32'h00000000);
        chk("rst_frame_done", 32'(bus0.frame_done), 32'h00000000);

        // Load 4,5,6,7 into digits 0..3 right after reset release.
        exp_seg[0] = 7'h19;
        exp_seg[1] = 7'h12;
        exp_seg[2] = 7'h02;
        exp_seg[3] = 7'h78;
        reset    = 1'b0;
        cyc      = 0;
        bus0.wr  = 1'b1;
        bus0.sel = 2'd0;
        bus0.num = 4'h4;
        step_u0();
        bus0.sel = 2'd1;
        bus0.num = 4'h5;
        step_u0();
        bus0.sel = 2'd2;
        bus0.num = 4'h6;
        step_u0();
        bus0.sel = 2'd3;
        bus0.num = 4'h7;
        step_u0();
        bus0.wr  = 1'b0;

        // Three full frames of free-running scan.
        repeat (116) step_u0();

        // Digits 0 and 2 masked for one frame.
        bus0.en_mask = 4'b1010;
        exp_mask     = 4'b1010;
        repeat (40) step_u0();
        bus0.en_mask = 4'hF;
        exp_mask     = 4'hF;

        // Mid-slot write to digit 2 (driven on cycles 182..189).
        repeat (24) step_u0();
        bus0.wr  = 1'b1;
        bus0.sel = 2'd2;
        bus0.num = 4'hA;
        step_u0();
        bus0.wr    = 1'b0;
        exp_seg[2] = 7'h08;

        // Write sampled on the exit edge of digit 2's slot (cycle 229 -> 230).
        repeat (44) step_u0();
        bus0.wr  = 1'b1;
        bus0.sel = 2'd2;
        bus0.num = 4'h8;
        step_u0();
        bus0.wr    = 1'b0;
        exp_seg[2] = 7'h00;
        repeat (50) step_u0();

        // Asynchronous reset between edges during digit 0's slot.
        repeat (4) step_u0();
        chk("pre_async_anode", 32'(bus0.anode), 32'h0000000E);
        #2;
        reset = 1'b1;
        #1;
        chk("async_anode",      32'(bus0.anode),      32'h0000000F);
        chk("async_cathode",    32'(bus0.cathode),    32'h0000007F);
        chk("async_frame_done", 32'(bus0.frame_done), 32'h00000000);
        chk("async_digit_idx",  32'(bus0.digit_idx),  32'h00000000);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 4; i++) exp_seg[i] = 7'h40;
        repeat (40) step_u0();

        // No-blank build: digit 2 written with 0xA just after release.
        exp_seg1[0] = 7'h40;
        exp_seg1[1] = 7'h40;
        exp_seg1[2] = 7'h08;
        exp_seg1[3] = 7'h40;
        rst1 = 1'b0;
        c1   = 0;
        repeat (3) step_u1();
        bus1.wr  = 1'b1;
        bus1.sel = 2'd2;
        bus1.num = 4'hA;
        step_u1();
        bus1.wr = 1'b0;
        repeat (64) step_u1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit common-anode seven-segment display. Holds one digit register per position and exposes a write port (wr/sel/num). Cycles through the digits with a programmable on-time and inserts a blanking gap between digits to suppress ghosting. Sits between the user-input logic and the board pins, driving anode/cathode directly.

Parameters:
N_DIGITS, 4, number of digit positions; fixed at 4 in this revision.
REFRESH_CNT, 50000, clock cycles each digit is driven; must be >= 1.
BLANK_CNT, 500, clock cycles all digits are off between digits; 0 disables blanking.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr  in  1  write strobe; sampled on rising clk
sel  in  2  digit index for write
num  in  4  hex value to store (0x0-0xF)
en_mask  in  4  per-digit enable; 0 keeps that digit dark during its slot
anode  out  4  active-low digit enables, registered
cathode  out  7  active-low segments {g,f,e,d,c,b,a}, registered
digit_idx  out  2  index of the current or next slot
frame_done  out  1  one-cycle pulse at end of the last digit's DRIVE slot

Behaviour:
- Reset (async, immediate, also mid-scan): state=BLANK, digit_idx=0, counters=0, all digit regs=0x0, anode=4'b1111, cathode=7'b1111111, frame_done=0.
- Write: wr=1 at edge k stores num into reg[sel] at edge k. Writes accepted in any state. Reset has priority over wr.
- FSM, two states:
  - BLANK: anode=1111, cathode=1111111. After BLANK_CNT cycles, go to DRIVE. If BLANK_CNT=0, skip BLANK entirely.
  - DRIVE: anode[digit_idx]=0 if en_mask[digit_idx]=1, otherwise 1111. cathode=decode(reg[digit_idx]). Lasts REFRESH_CNT cycles. On exit, digit_idx <= (digit_idx+1) mod 4, then go to BLANK.
- Output timing:
  - Outputs are registered: a change to reg[digit_idx] or en_mask during DRIVE appears on the pins 1 cycle after the change.
  - First DRIVE of digit 0 begins BLANK_CNT cycles after reset deassert.
  - Frame period = 4*(REFRESH_CNT+BLANK_CNT) cycles.
- frame_done: asserted for exactly the cycle in which DRIVE of digit 3 completes (same edge digit_idx wraps 3->0).
- Counter width: clog2(max(REFRESH_CNT,BLANK_CNT)+1). The counter wraps to 0 at each state change, with no overflow.
- Simultaneous events:
  - Write to the digit being driven on its final DRIVE cycle: the value is stored but not shown until that digit's next slot.
  - en_mask toggled mid-slot: takes effect the next cycle.

Decomposition:
- Shared package ssd_pkg:
  - state enum {BLANK, DRIVE}
  - SEG_OFF=7'h7F, ANODE_OFF=4'hF
  - 16-entry hex segment table. Active-low {g..a}; entries include 0=7'h40, 1=7'h79, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, A=7'h08, F=7'h0E.
- One combinational sub-module, ssd_hex_decoder (4-bit in, 7-bit out), instantiated once on the mux output.

Test Plan:
All scenarios use REFRESH_CNT=8, BLANK_CNT=2.
1. Reset, then writes 4,5,6,7 to sel 0..3 with en_mask=1111 -> repeating pattern: anode 1110/cathode 7'h19, 1101/7'h12, 1011/7'h02, 0111/7'h78. Each digit held 8 cycles, separated by 2 cycles of anode=1111/cathode=7'h7F.
2. Free-run 3 frames -> frame_done pulses exactly 1 cycle wide, 40 cycles apart, coincident with digit_idx 3->0.
3. en_mask=1010 -> anode stays 1111 during slots 0 and 2. Slots 1 and 3 drive 1101 and 0111. Timing unchanged.
4. Write 0xA to sel=2 mid-DRIVE of digit 2 -> cathode changes to 7'h08 on the following cycle. Write to sel=2 on the final DRIVE cycle -> new value first appears in the next frame.
5. Assert reset asynchronously mid-DRIVE (between clock edges) -> anode=1111, cathode=7'h7F, frame_done=0 immediately. On release, digit 0 drives after 2 cycles with cathode=7'h40 (registers cleared).
6. Rebuild with BLANK_CNT=0 -> no blank gap. Anode steps 1110->1101->1011->0111 every 8 cycles. Frame period 32 cycles.
